// File: rtl/lsu_writeback_pkg.sv
// Shared definitions for the load/store writeback unit: funct3 codes, FSM state
// encodings and access-size decode helpers.
package lsu_writeback_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t S_IDLE = 2'd0;
  localparam lsu_state_t S_MEM  = 2'd1;
  localparam lsu_state_t S_WB   = 2'd2;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Unused codes fall back to a full word; BU/HU map onto the byte/half size.
  function automatic lsu_size_e decode_size(input logic [2:0] funct3);
    lsu_size_e size;
    case (funct3)
      F3_B, F3_BU: size = SZ_B;
      F3_H, F3_HU: size = SZ_H;
      default:     size = SZ_W;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_writeback_align.sv
// Combinational lane logic: store strobes and lane-replicated write data, plus
// load-lane extraction with sign/zero extension.
module lsu_align
  import lsu_writeback_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] ld_word_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ld_data_o
);

  lsu_size_e size_s;
  logic      sext_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign size_s = decode_size(funct3_i);
  assign sext_s = ~funct3_i[2];

  // Store side: strobes follow the truncated lane for misaligned halves/words.
  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = st_data_i;
    case (size_s)
      SZ_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
      end
      SZ_W: begin
        wstrb_o = 4'b1111;
        wdata_o = st_data_i;
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    byte_s = ld_word_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_s = ld_word_i[7:0];
      2'd1:    byte_s = ld_word_i[15:8];
      2'd2:    byte_s = ld_word_i[23:16];
      2'd3:    byte_s = ld_word_i[31:24];
      default: byte_s = ld_word_i[7:0];
    endcase
  end

  assign half_s = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  always_comb begin
    ld_data_o = ld_word_i;
    case (size_s)
      SZ_B: begin
        if (sext_s) begin
          ld_data_o = {{24{byte_s[7]}}, byte_s};
        end else begin
          ld_data_o = {24'd0, byte_s};
        end
      end
      SZ_H: begin
        if (sext_s) begin
          ld_data_o = {{16{half_s[15]}}, half_s};
        end else begin
          ld_data_o = {16'd0, half_s};
        end
      end
      SZ_W:    ld_data_o = ld_word_i;
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_writeback.sv
// Load/store unit: one request at a time, IDLE -> MEM -> WB, register-bank write
// on loads. Optional misaligned trap when MISALIGN_TRAP_EN is defined.
module lsu_writeback
  import lsu_writeback_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_wstrb_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rf_wr_en_o,
  output logic [4:0]        rf_rd_addr_o,
  output logic [XLEN-1:0]   rf_data_o,
  output logic              done_o,
  output logic              err_o
);

  lsu_state_t        state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   ldata_q;

  logic            accept_s;
  logic            trap_s;
  logic            in_mem_s;
  logic            in_wb_s;
  logic            err_wb_s;
  logic            rf_wr_s;
  logic [3:0]      al_wstrb_s;
  logic [XLEN-1:0] al_wdata_s;
  logic [XLEN-1:0] al_ld_s;

  assign accept_s = req_valid_i && (state_q == S_IDLE);
  assign in_mem_s = (state_q == S_MEM);
  assign in_wb_s  = (state_q == S_WB);

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  assign trap_s = is_misaligned(decode_size(req_funct3_i), req_addr_i[1:0]);

  // Trap flag travels with the accepted request into WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept_s) begin
      err_q <= trap_s;
    end else begin
      err_q <= err_q;
    end
  end

  assign err_wb_s = in_wb_s && err_q;
`else
  assign trap_s   = 1'b0;
  assign err_wb_s = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = trap_s ? S_WB : S_MEM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEM: begin
        if (mem_ack_i) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 5'd0;
    end else if (accept_s) begin
      we_q     <= req_we_i;
      funct3_q <= req_funct3_i;
      addr_q   <= req_addr_i;
      wdata_q  <= req_wdata_i;
      rd_q     <= req_rd_i;
    end else begin
      we_q     <= we_q;
      funct3_q <= funct3_q;
      addr_q   <= addr_q;
      wdata_q  <= wdata_q;
      rd_q     <= rd_q;
    end
  end

  // Load data is aligned/extended on the ack edge so WB drives it straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldata_q <= '0;
    end else if (in_mem_s && mem_ack_i) begin
      ldata_q <= al_ld_s;
    end else begin
      ldata_q <= ldata_q;
    end
  end

  lsu_align u_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .st_data_i (wdata_q),
    .ld_word_i (mem_rdata_i),
    .wstrb_o   (al_wstrb_s),
    .wdata_o   (al_wdata_s),
    .ld_data_o (al_ld_s)
  );

  assign req_ready_o = (state_q == S_IDLE);

  assign mem_req_o   = in_mem_s;
  assign mem_we_o    = in_mem_s && we_q;
  assign mem_addr_o  = in_mem_s ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wstrb_o = (in_mem_s && we_q) ? al_wstrb_s : 4'b0000;
  assign mem_wdata_o = (in_mem_s && we_q) ? al_wdata_s : '0;

  // x0 is never written; trapped accesses never reach the register bank.
  assign rf_wr_s      = in_wb_s && !we_q && (rd_q != 5'd0) && !err_wb_s;
  assign rf_wr_en_o   = rf_wr_s;
  assign rf_rd_addr_o = rf_wr_s ? rd_q : 5'd0;
  assign rf_data_o    = rf_wr_s ? ldata_q : '0;

  assign done_o = in_wb_s;
  assign err_o  = err_wb_s;

endmodule
